// File: rtl/aes_pkg.sv
// Shared AES controller definitions: block width, round counts per key size
// and the sequencer state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: owns the block state, folds in round key 0
// itself and walks one shared external round datapath through rounds 1..NR.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = NR_128,
    parameter int RW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic                   key_req,
    output logic [RW-1:0]          key_idx,
    input  logic                   key_valid,
    input  logic [AES_BLOCK_W-1:0] key_data,
    output logic [AES_BLOCK_W-1:0] rd_state,
    output logic [AES_BLOCK_W-1:0] rd_key,
    output logic                   rd_final,
    input  logic [AES_BLOCK_W-1:0] rd_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   busy
);

    if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
        $error("aes_round_sequencer: NR must be 10, 12 or 14");
    end
    if ((2 ** RW) <= NR) begin : g_bad_rw
        $error("aes_round_sequencer: RW too narrow to hold round index NR");
    end

    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    seq_state_e             fsm_q, fsm_d;
    logic [RW-1:0]          round_q, round_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d;

    // NOTE: every output and next-state value gets a default before the case,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        fsm_d     = fsm_q;
        round_d   = round_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        key_req   = 1'b0;
        rd_final  = 1'b0;
        out_valid = 1'b0;

        unique case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_block;
                    round_d = '0;
                    fsm_d   = ST_KEY;
                end
            end

            ST_KEY: begin
                key_req  = 1'b1;
                rd_final = (round_q == LAST_ROUND);
                if (key_valid) begin
                    if (round_q == '0) begin
                        // Initial AddRoundKey needs no datapath pass.
                        data_d  = data_q ^ key_data;
                        round_d = round_q + RW'(1);
                    end else begin
                        data_d = rd_result;
                        if (round_q == LAST_ROUND) begin
                            fsm_d = ST_DONE;
                        end else begin
                            round_d = round_q + RW'(1);
                        end
                    end
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end

            default: fsm_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    // The wide block register is reset too: a discarded block must not linger
    // on rd_state after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            round_q <= '0;
            data_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            data_q  <= data_d;
        end
    end

    assign key_idx   = (fsm_q == ST_KEY) ? round_q : '0;
    assign rd_state  = data_q;
    assign rd_key    = key_data;
    assign out_block = (fsm_q == ST_DONE) ? data_q : '0;
    assign busy      = (fsm_q != ST_IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: a behavioural AES round and key expansion
// stand in for the external datapath and key source; ciphertexts are FIPS-197 vectors.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    localparam int RW = 4;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference AES pieces (the external datapath) ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int i = 1; i < 8; i++) begin
            base = gmul(base, base);
            inv  = gmul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int k = 0; k < 16; k++) b[k] = sbox(st[127-8*k -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[rr+4*c] = b[rr + 4*((c + rr) % 4)];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (!fin) begin
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = t[k];
        return r ^ rk;
    endfunction

    // Round key r lives at [r*128 +: 128]; key is left-aligned in 256 bits.
    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk,
                                                 input int nr);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rcon;
        logic [1919:0] res;
        rcon = 8'h01;
        res  = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp  = subword({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) res[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return res;
    endfunction

    // ---------------- DUT A: AES-128 ----------------
    logic           in_valid, in_ready, key_req, key_valid, rd_final;
    logic           out_valid, out_ready, busy;
    logic [RW-1:0]  key_idx;
    logic [127:0]   in_block, key_data, rd_state, rd_key, rd_result, out_block;
    logic [1919:0]  rks_a;

    assign key_data  = rks_a[int'(key_idx)*128 +: 128];
    assign rd_result = aes_round(rd_state, rd_key, rd_final);

    aes_round_sequencer #(.NR(NR_128), .RW(RW)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .key_req(key_req), .key_idx(key_idx), .key_valid(key_valid), .key_data(key_data),
        .rd_state(rd_state), .rd_key(rd_key), .rd_final(rd_final), .rd_result(rd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
    );

    // ---------------- DUT B: AES-256 ----------------
    logic           in_valid_b, in_ready_b, key_req_b, key_valid_b, rd_final_b;
    logic           out_valid_b, out_ready_b, busy_b;
    logic [RW-1:0]  key_idx_b;
    logic [127:0]   in_block_b, key_data_b, rd_state_b, rd_key_b, rd_result_b, out_block_b;
    logic [1919:0]  rks_b;

    assign key_valid_b = 1'b1;
    assign key_data_b  = rks_b[int'(key_idx_b)*128 +: 128];
    assign rd_result_b = aes_round(rd_state_b, rd_key_b, rd_final_b);

    aes_round_sequencer #(.NR(NR_256), .RW(RW)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
        .key_req(key_req_b), .key_idx(key_idx_b), .key_valid(key_valid_b), .key_data(key_data_b),
        .rd_state(rd_state_b), .rd_key(rd_key_b), .rd_final(rd_final_b), .rd_result(rd_result_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_block(out_block_b), .busy(busy_b)
    );

    // ---------------- checking and stimulus helpers ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One AES-128 block on DUT A. in_valid stays high with a junk block during KEY
    // to show it is ignored; optionally a next block is offered while DONE is held.
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int stall_len, input int bp_len,
                             input bit offer_next, input logic [127:0] next_pt,
                             input int exp_lat);
        int           cyc, stalls, fin_cnt, exp_idx;
        bit           seq_ok, fin_ok, stall_ok, held_set;
        logic [127:0] held;
        rks_a = expand_key({key, 128'h0}, 4, NR_128);
        in_block = pt;
        in_valid = 1'b1;
        key_valid = 1'b1;
        check({tag, " in_ready before accept"}, 128'(in_ready), 128'd1);
        tick();
        in_block = ~pt;
        cyc = 0; stalls = 0; fin_cnt = 0; exp_idx = 0;
        seq_ok = 1'b1; fin_ok = 1'b1; stall_ok = 1'b1; held_set = 1'b0; held = '0;
        while (!out_valid && cyc < 100) begin
            key_valid = 1'b1;
            if (key_req) begin
                if (int'(key_idx) != exp_idx) seq_ok = 1'b0;
                if (rd_final !== (int'(key_idx) == NR_128)) fin_ok = 1'b0;
                if (rd_final) fin_cnt++;
                if (stall_len > 0 && int'(key_idx) == 5) begin
                    if (!held_set) begin
                        held = rd_state;
                        held_set = 1'b1;
                    end else if (rd_state !== held) begin
                        stall_ok = 1'b0;
                    end
                end
                if (int'(key_idx) == 5 && stalls < stall_len) begin
                    key_valid = 1'b0;
                    stalls++;
                end else begin
                    exp_idx++;
                end
            end else if (rd_final) begin
                fin_ok = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = offer_next;
        in_block = next_pt;
        check({tag, " latency"}, 128'(cyc), 128'(exp_lat));
        check({tag, " key_idx sequence"}, 128'(seq_ok), 128'd1);
        check({tag, " rd_final placement"}, 128'(fin_ok), 128'd1);
        check({tag, " rd_final count"}, 128'(fin_cnt), 128'd1);
        if (stall_len > 0) begin
            check({tag, " rd_state held in stall"}, 128'(stall_ok), 128'd1);
            check({tag, " stall cycles"}, 128'(stalls), 128'(stall_len));
        end
        check({tag, " out_block"}, out_block, ct);
        check({tag, " busy in DONE"}, 128'(busy), 128'd1);
        for (int i = 0; i < bp_len; i++) begin
            tick();
            check({tag, " bp out_block stable"}, out_block, ct);
            check({tag, " bp out_valid"}, 128'(out_valid), 128'd1);
            check({tag, " bp in_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 128'(out_valid), 128'd0);
        check({tag, " busy after handshake"}, 128'(busy), 128'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 128'(in_ready), 128'd1);
        check({tag, " key_req"}, 128'(key_req), 128'd0);
        check({tag, " key_idx"}, 128'(key_idx), 128'd0);
        check({tag, " rd_final"}, 128'(rd_final), 128'd0);
        check({tag, " out_valid"}, 128'(out_valid), 128'd0);
        check({tag, " busy"}, 128'(busy), 128'd0);
        check({tag, " out_block"}, out_block, 128'd0);
        check({tag, " rd_state"}, rd_state, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        int  guard;
        bit  seen_ov;
        in_valid = 1'b0;   in_block = '0;   key_valid = 1'b0;   out_ready = 1'b0;
        in_valid_b = 1'b0; in_block_b = '0; out_ready_b = 1'b0;
        rks_a = expand_key({KEY_B, 128'h0}, 4, NR_128);
        rks_b = expand_key(KEY_C3, 8, NR_256);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // FIPS-197 App. B, keys always ready.
        run_block("appB", KEY_B, PT_B, CT_B, 0, 0, 1'b0, '0, NR_128 + 1);
        // FIPS-197 App. C.1, key_idx / rd_final trace.
        run_block("appC1", KEY_C1, PT_C, CT_C1, 0, 0, 1'b0, '0, NR_128 + 1);
        // Key source stalls three cycles at round 5.
        run_block("stall", KEY_B, PT_B, CT_B, 3, 0, 1'b0, '0, NR_128 + 4);
        // Output backpressure with a second block waiting on in_valid.
        run_block("bp1", KEY_B, PT_B, CT_B, 0, 4, 1'b1, PT_C, NR_128 + 1);
        run_block("bp2", KEY_C1, PT_C, CT_C1, 0, 0, 1'b0, '0, NR_128 + 1);

        // Reset in the middle of a block.
        rks_a = expand_key({KEY_C1, 128'h0}, 4, NR_128);
        in_block = PT_C;
        in_valid = 1'b1;
        key_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!(key_req && int'(key_idx) == 6) && guard < 50) begin
            tick();
            guard++;
        end
        check("midrst reached key_idx 6", 128'(key_idx), 128'd6);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_ov = 1'b0;
        repeat (15) begin
            tick();
            if (out_valid) seen_ov = 1'b1;
        end
        check("midrst no out_valid", 128'(seen_ov), 128'd0);
        run_block("postrst", KEY_C1, PT_C, CT_C1, 0, 0, 1'b0, '0, NR_128 + 1);

        // AES-256 instance, FIPS-197 App. C.3.
        check("nr14 key_req idle", 128'(key_req_b), 128'd0);
        check("nr14 in_ready", 128'(in_ready_b), 128'd1);
        in_block_b = PT_C;
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        cyc = 0;
        while (!out_valid_b && cyc < 100) begin
            tick();
            cyc++;
        end
        check("nr14 latency", 128'(cyc), 128'(NR_256 + 1));
        check("nr14 out_block", out_block_b, CT_C3);
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        check("nr14 busy after handshake", 128'(busy_b), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
